// File: rtl/nios_debug_host_pkg.sv
// nios_debug_host_pkg: shared types and constants for the Nios II debug virtual-JTAG host driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nios_debug_host_pkg;

  // Default geometry of the Nios II debug slave shift path
  localparam int SR_WIDTH_DEF = 38;
  localparam int IR_WIDTH_DEF = 2;

  // Virtual IR opcodes understood by the debug slave
  localparam logic [1:0] IR_OCIMEM    = 2'd0;
  localparam logic [1:0] IR_TRACE     = 2'd1;
  localparam logic [1:0] IR_BREAK     = 2'd2;
  localparam logic [1:0] IR_TRACECTRL = 2'd3;

  // Transfer sequencer states; RTI is only entered when the run-test-idle hold is built in
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_UIR   = 3'd1,
    ST_CDR   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_UDR   = 3'd4,
    ST_RTI   = 3'd5,
    ST_DONE  = 3'd6
  } state_e;

endpackage

// File: rtl/nios_debug_host_tck_gen.sv
// nios_debug_host_tck_gen: divided test clock, low half first, with one-cycle fall/rise markers.
// Latency: tck rises TCK_DIV clk after enable, period 2*TCK_DIV clk.
// Backpressure: none; deasserting en_i parks tck low and the divider at 0.
module nios_debug_host_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  output logic tck_o,
  output logic fall_pulse_o,
  output logic rise_pulse_o
);

  localparam logic [7:0] DIV_M1 = 8'(TCK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       tck_q, tck_d;
  logic       half_end;

  // The last clk of each half period; tck toggles on the following edge
  assign half_end     = en_i && (cnt_q == DIV_M1);
  assign rise_pulse_o = half_end && !tck_q;
  assign fall_pulse_o = half_end && tck_q;
  assign tck_o        = tck_q;

  // Divider next state: count within a half period, flip tck at the end of it
  always_comb begin
    cnt_d = cnt_q;
    tck_d = tck_q;
    if (!en_i) begin
      cnt_d = 8'd0;
      tck_d = 1'b0;
    end else if (half_end) begin
      cnt_d = 8'd0;
      tck_d = ~tck_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Divider registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= 8'd0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end

endmodule

// File: rtl/nios_debug_jtag_host_driver.sv
// nios_debug_jtag_host_driver: virtual-JTAG initiator for the Nios II debug slave (uir, cdr, sdr x SR_WIDTH, udr).
// Latency: rsp_valid_o rises (SR_WIDTH+3)*2*TCK_DIV+1 clk after acceptance (+8*TCK_DIV with the RTI hold).
// Backpressure: one command in flight; the response is held with tck parked low until rsp_ready_i.
// Optional build macro NIOS_DEBUG_HOST_RTI_HOLD_EN adds 4 run-test-idle tck periods after udr.
module nios_debug_jtag_host_driver
  import nios_debug_host_pkg::*;
#(
  parameter int SR_WIDTH = SR_WIDTH_DEF,
  parameter int IR_WIDTH = IR_WIDTH_DEF,
  parameter int TCK_DIV  = 2
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [IR_WIDTH-1:0] cmd_ir_i,
  input  logic [SR_WIDTH-1:0] cmd_data_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [SR_WIDTH-1:0] rsp_data_o,
  output logic [IR_WIDTH-1:0] rsp_ir_out_o,
  output logic                busy_o,
  output logic                vji_tck_o,
  output logic                vji_tdi_o,
  input  logic                vji_tdo_i,
  output logic [IR_WIDTH-1:0] vji_ir_in_o,
  input  logic [IR_WIDTH-1:0] vji_ir_out_i,
  output logic                vji_uir_o,
  output logic                vji_cdr_o,
  output logic                vji_sdr_o,
  output logic                vji_udr_o,
  output logic                vji_rti_o
);

  localparam int            CW       = (SR_WIDTH > 1) ? $clog2(SR_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(SR_WIDTH - 1);

  state_e state_q, state_d;

  // tck divider interface
  logic tck_en, tck_raw, fall_pulse, rise_pulse;
  // rise_pulse delayed to line up with the registered vji_tck_o rising edge
  logic rise_q;

  logic                accept;
  logic [IR_WIDTH-1:0] ir_q;
  logic [SR_WIDTH-1:0] tx_q;
  logic [SR_WIDTH-1:0] cap_q;
  logic [CW-1:0]       bit_cnt_q;
  logic                shift_done_q;
  logic                shift_last;
  logic                rsp_valid_q, rsp_valid_d;
  logic [IR_WIDTH-1:0] rsp_ir_q;

  // Pin-side registers: decoded from state_q and registered so they move with tck
  logic                tck_q;
  logic                tdi_q, tdi_d;
  logic [IR_WIDTH-1:0] ir_in_q, ir_in_d;
  logic                uir_q, uir_d;
  logic                cdr_q, cdr_d;
  logic                sdr_q, sdr_d;
  logic                udr_q, udr_d;
  logic                rti_q, rti_d;

`ifdef NIOS_DEBUG_HOST_RTI_HOLD_EN
  logic [1:0] rti_cnt_q;
`endif

  assign cmd_ready_o = (state_q == ST_IDLE) && !reset_i;
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign busy_o      = (state_q != ST_IDLE);
  assign tck_en      = (state_q != ST_IDLE) && (state_q != ST_DONE);

  // The last bit is done once its rising-point sample has been taken (now or earlier in the period)
  assign shift_last  = (bit_cnt_q == LAST_BIT) && (shift_done_q || rise_q);

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_data_o   = cap_q;
  assign rsp_ir_out_o = rsp_ir_q;
  assign vji_tck_o    = tck_q;
  assign vji_tdi_o    = tdi_q;
  assign vji_ir_in_o  = ir_in_q;
  assign vji_uir_o    = uir_q;
  assign vji_cdr_o    = cdr_q;
  assign vji_sdr_o    = sdr_q;
  assign vji_udr_o    = udr_q;
  assign vji_rti_o    = rti_q;

  nios_debug_host_tck_gen #(
    .TCK_DIV (TCK_DIV)
  ) u_tck_gen (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .en_i         (tck_en),
    .tck_o        (tck_raw),
    .fall_pulse_o (fall_pulse),
    .rise_pulse_o (rise_pulse)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: every virtual state advances at a tck falling point
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_UIR;
      ST_UIR:   if (fall_pulse) state_d = ST_CDR;
      ST_CDR:   if (fall_pulse) state_d = ST_SHIFT;
      ST_SHIFT: if (fall_pulse && shift_last) state_d = ST_UDR;
`ifdef NIOS_DEBUG_HOST_RTI_HOLD_EN
      ST_UDR:   if (fall_pulse) state_d = ST_RTI;
      ST_RTI:   if (fall_pulse && (rti_cnt_q == 2'd3)) state_d = ST_DONE;
`else
      ST_UDR:   if (fall_pulse) state_d = ST_DONE;
`endif
      ST_DONE:  if (rsp_valid_q && rsp_ready_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode of the current state toward the slave pins
  always_comb begin
    uir_d   = 1'b0;
    cdr_d   = 1'b0;
    sdr_d   = 1'b0;
    udr_d   = 1'b0;
    rti_d   = 1'b0;
    tdi_d   = 1'b0;
    ir_in_d = ir_in_q;
    case (state_q)
      ST_IDLE:  rti_d = 1'b1;
      ST_UIR: begin
        uir_d   = 1'b1;
        ir_in_d = ir_q;
      end
      ST_CDR:   cdr_d = 1'b1;
      ST_SHIFT: begin
        sdr_d = 1'b1;
        tdi_d = tx_q[0];
      end
      ST_UDR:   udr_d = 1'b1;
      ST_RTI:   rti_d = 1'b1;
      ST_DONE:  rti_d = 1'b1;
      default:  rti_d = 1'b1;
    endcase
  end

  // Pin registers: one clk behind state_q, so strobes, tdi and tck change together
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tck_q   <= 1'b0;
      tdi_q   <= 1'b0;
      ir_in_q <= '0;
      uir_q   <= 1'b0;
      cdr_q   <= 1'b0;
      sdr_q   <= 1'b0;
      udr_q   <= 1'b0;
      rti_q   <= 1'b1;
    end else begin
      tck_q   <= tck_raw;
      tdi_q   <= tdi_d;
      ir_in_q <= ir_in_d;
      uir_q   <= uir_d;
      cdr_q   <= cdr_d;
      sdr_q   <= sdr_d;
      udr_q   <= udr_d;
      rti_q   <= rti_d;
    end
  end

  // Response valid rises the clk after DONE is entered and drops on the handshake edge
  always_comb begin
    rsp_valid_d = (state_q == ST_DONE) && !(rsp_valid_q && rsp_ready_i);
  end

  // Command latch, tdi shifter, tdo capture, bit counter and CDR ir_out sample
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rise_q       <= 1'b0;
      ir_q         <= '0;
      tx_q         <= '0;
      cap_q        <= '0;
      bit_cnt_q    <= '0;
      shift_done_q <= 1'b0;
      rsp_ir_q     <= '0;
      rsp_valid_q  <= 1'b0;
    end else begin
      rise_q      <= rise_pulse;
      rsp_valid_q <= rsp_valid_d;
      if (accept) begin
        ir_q         <= cmd_ir_i;
        tx_q         <= cmd_data_i;
        bit_cnt_q    <= '0;
        shift_done_q <= 1'b0;
      end
      if (fall_pulse && (state_q == ST_SHIFT)) begin
        tx_q <= tx_q >> 1;
      end
      if (rise_q && (state_q == ST_CDR)) begin
        rsp_ir_q <= vji_ir_out_i;
      end
      if (rise_q && (state_q == ST_SHIFT)) begin
        cap_q <= {vji_tdo_i, cap_q[SR_WIDTH-1:1]};
        if (bit_cnt_q == LAST_BIT) begin
          shift_done_q <= 1'b1;
        end else begin
          bit_cnt_q <= bit_cnt_q + 1'b1;
        end
      end
    end
  end

`ifdef NIOS_DEBUG_HOST_RTI_HOLD_EN
  // Counts the run-test-idle tck periods held after udr
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rti_cnt_q <= 2'd0;
    end else if (accept) begin
      rti_cnt_q <= 2'd0;
    end else if (fall_pulse && (state_q == ST_RTI)) begin
      rti_cnt_q <= rti_cnt_q + 2'd1;
    end
  end
`endif

endmodule

// File: tb/tb_nios_debug_jtag_host_driver.sv
// tb_nios_debug_jtag_host_driver: scoreboard bench with a loopback slave model per DUT instance.
// Instance 0 runs TCK_DIV=2, instance 1 runs TCK_DIV=1.
// Honours NIOS_DEBUG_HOST_RTI_HOLD_EN for the expected latency and run-test-idle period count.
module tb_nios_debug_jtag_host_driver;
  import nios_debug_host_pkg::*;

  localparam int SR = 38;
  localparam int IR = 2;

  typedef struct packed {
    logic [31:0]   inst;
    logic [SR-1:0] data;
    logic [IR-1:0] ir;
    logic [31:0]   acc;
    logic [31:0]   lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          cv [2];
  logic          cr [2];
  logic [IR-1:0] cir [2];
  logic [SR-1:0] cdat [2];
  logic          rv [2];
  logic          rr [2];
  logic [SR-1:0] rdat [2];
  logic [IR-1:0] rir [2];
  logic          bsy [2];
  logic          tck [2];
  logic          tdi [2];
  logic          tdo [2];
  logic [IR-1:0] irin [2];
  logic [IR-1:0] irout [2];
  logic          uir [2];
  logic          cdr [2];
  logic          sdr [2];
  logic          udr [2];
  logic          rti [2];

  nios_debug_jtag_host_driver #(.SR_WIDTH(SR), .IR_WIDTH(IR), .TCK_DIV(2)) u0 (
    .clk_i(clk), .reset_i(rst), .cmd_valid_i(cv[0]), .cmd_ready_o(cr[0]),
    .cmd_ir_i(cir[0]), .cmd_data_i(cdat[0]), .rsp_valid_o(rv[0]), .rsp_ready_i(rr[0]),
    .rsp_data_o(rdat[0]), .rsp_ir_out_o(rir[0]), .busy_o(bsy[0]), .vji_tck_o(tck[0]),
    .vji_tdi_o(tdi[0]), .vji_tdo_i(tdo[0]), .vji_ir_in_o(irin[0]), .vji_ir_out_i(irout[0]),
    .vji_uir_o(uir[0]), .vji_cdr_o(cdr[0]), .vji_sdr_o(sdr[0]), .vji_udr_o(udr[0]),
    .vji_rti_o(rti[0]));

  nios_debug_jtag_host_driver #(.SR_WIDTH(SR), .IR_WIDTH(IR), .TCK_DIV(1)) u1 (
    .clk_i(clk), .reset_i(rst), .cmd_valid_i(cv[1]), .cmd_ready_o(cr[1]),
    .cmd_ir_i(cir[1]), .cmd_data_i(cdat[1]), .rsp_valid_o(rv[1]), .rsp_ready_i(rr[1]),
    .rsp_data_o(rdat[1]), .rsp_ir_out_o(rir[1]), .busy_o(bsy[1]), .vji_tck_o(tck[1]),
    .vji_tdi_o(tdi[1]), .vji_tdo_i(tdo[1]), .vji_ir_in_o(irin[1]), .vji_ir_out_i(irout[1]),
    .vji_uir_o(uir[1]), .vji_cdr_o(cdr[1]), .vji_sdr_o(sdr[1]), .vji_udr_o(udr[1]),
    .vji_rti_o(rti[1]));

  // Loopback slave model: tdo is the model LSB, model shifts tdi in on each tck rise during sdr
  logic [SR-1:0] model [2];
  logic          load [2];
  logic [SR-1:0] load_val [2];
  logic          tck_p [2];
  logic          udr_p [2];
  int            sdr_cnt [2];
  int            tdi_hi [2];
  int            rti_cnt [2];
  int            udr_cnt [2];

  assign tdo[0] = model[0][0];
  assign tdo[1] = model[1][0];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      tck_p[i] <= tck[i];
      udr_p[i] <= udr[i];
      if (load[i]) begin
        model[i]   <= load_val[i];
        sdr_cnt[i] <= 0;
        tdi_hi[i]  <= 0;
        rti_cnt[i] <= 0;
        udr_cnt[i] <= 0;
      end else begin
        if (tck[i] && !tck_p[i]) begin
          if (sdr[i]) begin
            model[i]   <= {tdi[i], model[i][SR-1:1]};
            sdr_cnt[i] <= sdr_cnt[i] + 1;
            if (tdi[i]) tdi_hi[i] <= tdi_hi[i] + 1;
          end
          if (rti[i]) rti_cnt[i] <= rti_cnt[i] + 1;
        end
        if (udr[i] && !udr_p[i]) udr_cnt[i] <= udr_cnt[i] + 1;
      end
    end
  end

  exp_t sbq [$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_rsp   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Hand-computed latencies: (38+3)*2*DIV+1, plus 8*DIV with the RTI hold
  function automatic int lat_of(input int i);
`ifdef NIOS_DEBUG_HOST_RTI_HOLD_EN
    return (i == 0) ? 181 : 91;
`else
    return (i == 0) ? 165 : 83;
`endif
  endfunction

  function automatic int rti_exp();
`ifdef NIOS_DEBUG_HOST_RTI_HOLD_EN
    return 4;
`else
    return 0;
`endif
  endfunction

  task automatic monitor();
    exp_t e;
    logic prev [2];
    prev[0] = 1'b0;
    prev[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rv[i] && !prev[i]) begin
          n_rsp++;
          check("rsp_expected", (sbq.size() != 0), 1);
          if (sbq.size() != 0) begin
            e = sbq.pop_front();
            check("rsp_inst", i, e.inst);
            check("rsp_data", rdat[i], e.data);
            check("rsp_ir_out", rir[i], e.ir);
            check("rsp_latency", cyc - e.acc, e.lat);
          end
        end
        prev[i] = rv[i];
      end
    end
  endtask

  task automatic load_model(input int i, input logic [SR-1:0] v);
    @(negedge clk);
    load[i]     = 1'b1;
    load_val[i] = v;
    @(negedge clk);
    load[i]     = 1'b0;
  endtask

  task automatic send(input int i, input logic [IR-1:0] ir, input logic [SR-1:0] d,
                      input logic [SR-1:0] exp_d, input logic [IR-1:0] exp_ir, input bit expect_rsp);
    exp_t e;
    int   n;
    @(negedge clk);
    cv[i]   = 1'b1;
    cir[i]  = ir;
    cdat[i] = d;
    n = 0;
    while (!cr[i] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", cr[i], 1);
    @(posedge clk);
    #1;
    cv[i] = 1'b0;
    if (expect_rsp) begin
      e.inst = i;
      e.data = exp_d;
      e.ir   = exp_ir;
      e.acc  = cyc;
      e.lat  = lat_of(i);
      sbq.push_back(e);
    end
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("rsp_timeout", sbq.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset(input int i, input logic ready_exp);
    check("rst_cmd_ready", cr[i], ready_exp);
    check("rst_rsp_valid", rv[i], 0);
    check("rst_rsp_data", rdat[i], 0);
    check("rst_rsp_ir_out", rir[i], 0);
    check("rst_busy", bsy[i], 0);
    check("rst_tck", tck[i], 0);
    check("rst_tdi", tdi[i], 0);
    check("rst_ir_in", irin[i], 0);
    check("rst_strobes", {uir[i], cdr[i], sdr[i], udr[i]}, 4'b0000);
    check("rst_rti", rti[i], 1);
  endtask

  initial begin
    int n, r0, bv, bd, bc, bt, bb;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cv[i] = 1'b0; rr[i] = 1'b1; cir[i] = '0; cdat[i] = '0; irout[i] = '0;
      load[i] = 1'b1; load_val[i] = '0;
    end
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    check("reset_cmd_ready0", cr[0], 0);
    check("reset_cmd_ready1", cr[1], 0);
    rst = 1'b0;
    load[0] = 1'b0;
    load[1] = 1'b0;
    @(negedge clk);
    chk_reset(0, 1'b1);
    chk_reset(1, 1'b1);

    // Loopback, IR=break, slave ir_out=2'b10
    load_model(0, 38'h15_0F0F_F0F0);
    irout[0] = 2'b10;
    send(0, IR_BREAK, 38'h2A_5A5A_5A5A, 38'h15_0F0F_F0F0, 2'b10, 1'b1);
    wait_rsp();
    check("loop_model", model[0], 38'h2A_5A5A_5A5A);
    check("loop_ir_in", irin[0], 2'd2);
    check("loop_sdr_periods", sdr_cnt[0], 38);
    check("loop_udr_count", udr_cnt[0], 1);
    check("loop_rti_periods", rti_cnt[0], rti_exp());
    check("loop_tck_idle", tck[0], 0);
    check("loop_rti_idle", rti[0], 1);

    // TCK_DIV=1, single set bit in frame
    load_model(1, 38'h00_DEAD_BEEF);
    irout[1] = 2'b01;
    send(1, IR_TRACE, 38'h1, 38'h00_DEAD_BEEF, 2'b01, 1'b1);
    wait_rsp();
    check("div1_sdr_periods", sdr_cnt[1], 38);
    check("div1_tdi_high", tdi_hi[1], 1);
    check("div1_model", model[1], 38'h1);
    check("div1_ir_in", irin[1], 2'd1);

    // Response backpressure for 50 cycles
    load_model(0, 38'h3A_1234_5678);
    irout[0] = 2'b11;
    rr[0] = 1'b0;
    send(0, IR_OCIMEM, 38'h05_5555_AAAA, 38'h3A_1234_5678, 2'b11, 1'b1);
    n = 0;
    while (!rv[0] && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("bp_rsp_seen", rv[0], 1);
    bv = 0; bd = 0; bc = 0; bt = 0; bb = 0;
    repeat (50) begin
      @(negedge clk);
      if (!rv[0]) bv++;
      if (rdat[0] !== 38'h3A_1234_5678) bd++;
      if (cr[0]) bc++;
      if (tck[0]) bt++;
      if (!bsy[0]) bb++;
    end
    check("bp_valid_held", bv, 0);
    check("bp_data_stable", bd, 0);
    check("bp_ready_low", bc, 0);
    check("bp_tck_low", bt, 0);
    check("bp_busy", bb, 0);
    rr[0] = 1'b1;
    @(negedge clk);
    check("bp_valid_drop", rv[0], 0);
    check("bp_ready_after", cr[0], 1);
    check("bp_model", model[0], 38'h05_5555_AAAA);

    // Reset during shift bit 20, then a clean transfer
    load_model(0, 38'h11_2233_4455);
    send(0, IR_TRACECTRL, 38'h0F_0000_FFFF, '0, '0, 1'b0);
    n = 0;
    while (sdr_cnt[0] < 20 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("abort_reach_bit20", sdr_cnt[0], 20);
    rst = 1'b1;
    @(negedge clk);
    chk_reset(0, 1'b0);
    rst = 1'b0;
    r0 = n_rsp;
    repeat (300) @(negedge clk);
    check("abort_no_udr", udr_cnt[0], 0);
    check("abort_no_rsp", n_rsp, r0);
    check("abort_idle_ready", cr[0], 1);
    load_model(0, 38'h2B_CAFE_0001);
    irout[0] = 2'b01;
    send(0, IR_TRACE, 38'h14_8421_1248, 38'h2B_CAFE_0001, 2'b01, 1'b1);
    wait_rsp();
    check("post_abort_model", model[0], 38'h14_8421_1248);
    check("post_abort_udr", udr_cnt[0], 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nios_debug_jtag_host_driver.md
Name: nios_debug_jtag_host_driver

Overview:
- Initiator side of the Nios II debug-slave virtual-JTAG link, for simulation and on-chip self-test.
- Takes one command at a time: a 2-bit IR plus a 38-bit data frame.
- Generates the virtual-JTAG pin sequence the debug slave expects (uir, cdr, sdr ×38, udr) with a divided tck.
- Shifts the frame into the slave, captures the slave's tdo stream and ir_out, and returns both as a response.

Parameters:
- SR_WIDTH, 38, length of the debug shift register in bits.
- IR_WIDTH, 2, virtual IR width.
- TCK_DIV, 2, clk cycles per tck half-period; legal range 1..255.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  driver idle and able to accept a command.
- cmd_ir  in  IR_WIDTH  IR value for this transfer.
- cmd_data  in  SR_WIDTH  frame to shift in, LSB first.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_data  out  SR_WIDTH  captured tdo frame.
- rsp_ir_out  out  IR_WIDTH  ir_out sampled during CDR.
- busy  out  1  high in every state except IDLE.
- vji_tck  out  1  generated test clock.
- vji_tdi  out  1  serial data to slave.
- vji_tdo  in  1  serial data from slave.
- vji_ir_in  out  IR_WIDTH  IR presented to slave.
- vji_ir_out  in  IR_WIDTH  slave status IR.
- vji_uir, vji_cdr, vji_sdr, vji_udr  out  1 each  virtual state strobes.
- vji_rti  out  1  run-test-idle indicator.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values:
  - cmd_ready=0 during reset, 1 on the first cycle after.
  - rsp_valid=0, rsp_data=0, rsp_ir_out=0, busy=0.
  - vji_tck=0, vji_tdi=0, vji_ir_in=0.
  - All strobes=0, vji_rti=1.
- Handshakes:
  - Command accepted when cmd_valid&&cmd_ready.
  - cmd_ready=1 only in IDLE.
  - cmd_ir and cmd_data are latched on acceptance.
- tck generation:
  - Each tck period is 2*TCK_DIV clk cycles: low half then high half.
  - tck rises after TCK_DIV cycles low.
  - Outputs change only at falling-edge points; inputs are sampled on the clk cycle where tck rises.
- States, each lasting exactly one tck period unless stated:
  - IDLE: vji_rti=1. Goes to UIR on acceptance.
  - UIR: vji_ir_in=cmd_ir; vji_uir=1. vji_ir_in holds this value until the next command.
  - CDR: vji_cdr=1. rsp_ir_out<=vji_ir_out sampled at the rising tck point.
  - SHIFT: SR_WIDTH tck periods with vji_sdr=1.
    - vji_tdi = bit k of the frame, set at the falling point.
    - At each rising point: capture <= {vji_tdo, capture[SR_WIDTH-1:1]}.
    - A bit counter runs 0..SR_WIDTH-1; leave SHIFT when the count reaches SR_WIDTH-1 at a rising point, with no wrap past.
  - UDR: vji_udr=1; tdi returns to 0.
  - DONE: rsp_valid=1 with rsp_data=capture. Held until rsp_valid&&rsp_ready, then IDLE.
- Latency: rsp_valid rises (SR_WIDTH+3)*2*TCK_DIV+1 clk cycles after the accepting edge. That is 165 for the defaults.
- Backpressure: while in DONE, cmd_ready=0 and tck stays low. Nothing is lost.
- Back-to-back commands: the earliest re-acceptance is the cycle after the response handshake. vji_rti is 1 for at least one clk cycle between transfers.
- Reset mid-operation: the next edge forces all reset values.
  - No UDR is emitted for the aborted frame.
  - The partial capture is discarded and no response is issued.
- Strobes are mutually exclusive. vji_tck is never high while in IDLE or DONE.

Optional Feature:
- Macro: NIOS_DEBUG_HOST_RTI_HOLD_EN.
- Defined:
  - New state RTI between UDR and DONE, lasting 4 tck periods with vji_rti=1 and tck toggling.
  - This lets the slave's st_ready_test_idle handshake settle before the response.
  - Latency grows by 8*TCK_DIV.
- Undefined: UDR goes directly to DONE, and vji_rti=1 only in IDLE and DONE.

Decomposition:
- Package nios_debug_host_pkg holds:
  - The state enum (IDLE, UIR, CDR, SHIFT, UDR, RTI, DONE).
  - SR_WIDTH and IR_WIDTH defaults.
  - The IR opcode constants: 0 ocimem, 1 trace, 2 break, 3 tracectrl.
- One sub-module, nios_debug_host_tck_gen.
  - Contains the TCK_DIV counter; outputs tck, fall_pulse and rise_pulse.
  - Has an enable input; when disabled it holds tck low and the counter at 0.

Test Plan:
- Loopback model: tdo = model_sr[0], model_sr shifts on sdr at tck rise. cmd_ir=2, cmd_data=38'h2A_5A5A_5A5A preloaded with model 38'h15_0F0F_F0F0 -> rsp_data=38'h15_0F0F_F0F0, model holds 38'h2A_5A5A_5A5A, rsp_valid at cycle 165.
- TCK_DIV=1, cmd_data=38'h1 -> exactly 38 sdr tck periods, tdi high only in the first; rsp_valid at cycle 83.
- Slave ir_out=2'b10 during CDR -> rsp_ir_out=2'b10.
- Hold rsp_ready=0 for 50 cycles -> rsp_valid stays 1, data stable, cmd_ready=0, tck low; handshake then cmd_ready=1 on the next cycle.
- Assert reset at shift bit 20 -> next cycle all outputs at reset values, no udr, no rsp_valid; a following command completes correctly.
- With NIOS_DEBUG_HOST_RTI_HOLD_EN defined -> 4 rti tck periods after udr; defaults give rsp_valid at cycle 181.
